// File: rtl/alien_fleet_controller_if.sv
// Signal bundle between the alien fleet controller and the game logic around it:
// motion tick, wave start, laser position in, fleet state out.
interface alien_fleet_controller_if #(
   parameter int NA = 36
);
   logic          enable;
   logic          start;
   logic          laserActive;
   logic [9:0]    xLaser;
   logic [9:0]    yLaser;
   logic          killingAlien;
   logic [9:0]    xAlien;
   logic [9:0]    yAlien;
   logic [NA-1:0] alive;
   logic          canLeft;
   logic          canRight;
   logic          win;
   logic          lose;

   modport master (
      output enable, start, laserActive, xLaser, yLaser,
      input  killingAlien, xAlien, yAlien, alive, canLeft, canRight, win, lose
   );

   modport slave (
      input  enable, start, laserActive, xLaser, yLaser,
      output killingAlien, xAlien, yAlien, alive, canLeft, canRight, win, lose
   );
endinterface

// File: rtl/alien_fleet_controller.sv
// Alien formation sequencer: zig-zag march/descend on the motion tick, laser hit
// resolution against the alive mask, and win/lose detection.
module alien_fleet_controller #(
   parameter int COLS      = 6,
   parameter int ROWS      = 6,
   parameter int SPACING_X = 64,
   parameter int SPACING_Y = 32,
   parameter int ALIEN_W   = 32,
   parameter int ALIEN_H   = 16,
   parameter int X_START   = 64,
   parameter int Y_START   = 32,
   parameter int STEP_X    = 8,
   parameter int STEP_Y    = 16,
   parameter int SCREEN_W  = 640,
   parameter int Y_LIMIT   = 400
) (
   input logic                     clk,
   input logic                     reset,
   alien_fleet_controller_if.slave bus
);

   localparam int NA  = COLS * ROWS;
   localparam int SXS = $clog2(SPACING_X);
   localparam int SYS = $clog2(SPACING_Y);

   typedef enum logic [1:0] {IDLE, MOVE, DESCEND, OVER} state_t;
   typedef enum logic {RIGHT, LEFT} dir_t;

   state_t        state_q, state_d;
   dir_t          dir_q, dir_d;
   logic [NA-1:0] alive_q, alive_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          kill_q, kill_d;
   logic          win_q, win_d;
   logic          lose_q, lose_d;
   logic          lock_q, lock_d;

   logic [COLS-1:0] colAny;
   logic [ROWS-1:0] rowAny;
   logic [10:0]     leftCol, rightCol, botRow;
   logic            anyAlive;
   logic [10:0]     lEdge, rEdge, bEdge;
   logic            canL, canR, atLimit;

   always_comb begin
      colAny   = '0;
      rowAny   = '0;
      leftCol  = '0;
      rightCol = '0;
      botRow   = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (alive_q[r*COLS+c]) begin
               colAny[c] = 1'b1;
               rowAny[r] = 1'b1;
            end
         end
      end
      for (int c = COLS - 1; c >= 0; c--) begin
         if (colAny[c]) leftCol = 11'(c);
      end
      for (int c = 0; c < COLS; c++) begin
         if (colAny[c]) rightCol = 11'(c);
      end
      for (int r = 0; r < ROWS; r++) begin
         if (rowAny[r]) botRow = 11'(r);
      end
   end

   // Edge arithmetic is 11 bits wide so the sums can never wrap.
   assign anyAlive = |alive_q;
   assign lEdge    = {1'b0, x_q} + (leftCol << SXS);
   assign rEdge    = {1'b0, x_q} + (rightCol << SXS) + 11'(ALIEN_W + STEP_X);
   assign bEdge    = {1'b0, y_q} + (botRow << SYS) + 11'(ALIEN_H);
   assign canL     = anyAlive && (lEdge >= 11'(STEP_X));
   assign canR     = anyAlive && (rEdge <= 11'(SCREEN_W));
   assign atLimit  = anyAlive && (bEdge >= 11'(Y_LIMIT));

   logic signed [10:0] dx, dy;
   logic [10:0]        hCol, hRow, dxMod, dyMod;
   logic [NA-1:0]      hitMask;
   logic               inPlay, hit;

   assign dx     = $signed({1'b0, bus.xLaser}) - $signed({1'b0, x_q});
   assign dy     = $signed({1'b0, bus.yLaser}) - $signed({1'b0, y_q});
   assign hCol   = $unsigned(dx) >> SXS;
   assign hRow   = $unsigned(dy) >> SYS;
   assign dxMod  = $unsigned(dx) & 11'(SPACING_X - 1);
   assign dyMod  = $unsigned(dy) & 11'(SPACING_Y - 1);
   assign inPlay = (state_q == MOVE) || (state_q == DESCEND);

   // Only an in-range cell can be selected, so the alive lookup never indexes past the mask.
   always_comb begin
      hitMask = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (hRow == 11'(r) && hCol == 11'(c)) hitMask[r*COLS+c] = 1'b1;
         end
      end
   end

   assign hit = inPlay && bus.laserActive && !lock_q && !dx[10] && !dy[10] &&
                (dxMod < 11'(ALIEN_W)) && (dyMod < 11'(ALIEN_H)) && |(alive_q & hitMask);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      alive_d = alive_q;
      x_d     = x_q;
      y_d     = y_q;
      kill_d  = 1'b0;
      win_d   = win_q;
      lose_d  = lose_q;
      lock_d  = bus.laserActive ? lock_q : 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (bus.start) begin
               state_d = MOVE;
               dir_d   = RIGHT;
               alive_d = '1;
               x_d     = 10'(X_START);
               y_d     = 10'(Y_START);
               win_d   = 1'b0;
               lose_d  = 1'b0;
               lock_d  = 1'b0;
            end
         end
         default: begin
            if (hit) begin
               alive_d = alive_q & ~hitMask;
               kill_d  = 1'b1;
               lock_d  = 1'b1;
            end
            // Win outranks lose and motion; either ending freezes the fleet where it stands.
            if (alive_d == '0) begin
               state_d = OVER;
               win_d   = 1'b1;
            end else if (atLimit) begin
               state_d = OVER;
               lose_d  = 1'b1;
            end else if (bus.enable) begin
               if (state_q == DESCEND) begin
                  y_d     = y_q + 10'(STEP_Y);
                  dir_d   = (dir_q == RIGHT) ? LEFT : RIGHT;
                  state_d = MOVE;
               end else if (dir_q == RIGHT && canR) begin
                  x_d = x_q + 10'(STEP_X);
               end else if (dir_q == LEFT && canL) begin
                  x_d = x_q - 10'(STEP_X);
               end else begin
                  state_d = DESCEND;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         dir_q   <= RIGHT;
         alive_q <= '0;
         x_q     <= 10'(X_START);
         y_q     <= 10'(Y_START);
         kill_q  <= 1'b0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         alive_q <= alive_d;
         x_q     <= x_d;
         y_q     <= y_d;
         kill_q  <= kill_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
         lock_q  <= lock_d;
      end
   end

   assign bus.killingAlien = kill_q;
   assign bus.xAlien       = x_q;
   assign bus.yAlien       = y_q;
   assign bus.alive        = alive_q;
   assign bus.canLeft      = canL;
   assign bus.canRight     = canR;
   assign bus.win          = win_q;
   assign bus.lose         = lose_q;

endmodule

// File: doc/alien_fleet_controller.md
Name: alien_fleet_controller

Overview:
- Sequences the 6x6 alien formation for the game.
- Owns the alive mask and the fleet origin (xAlien, yAlien) consumed by the alien colour stage.
- Runs the zig-zag march/descend state machine on the slow motion tick.
- Resolves laser-versus-alien hits, clears the struck alien and emits killingAlien back to the laser; reports win/lose.

Parameters:
- COLS, 6, aliens per row
- ROWS, 6, alien rows (COLS*ROWS = 36 = alive width)
- SPACING_X, 64, horizontal pitch in pixels (power of two)
- SPACING_Y, 32, vertical pitch in pixels (power of two)
- ALIEN_W, 32, sprite width (< SPACING_X)
- ALIEN_H, 16, sprite height (< SPACING_Y)
- X_START, 64, fleet origin x after start
- Y_START, 32, fleet origin y after start
- STEP_X, 8, pixels per march tick
- STEP_Y, 16, pixels per descend tick
- SCREEN_W, 640, right screen limit
- Y_LIMIT, 400, invasion line; lose when alive bottom edge reaches it

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  one-cycle motion tick (zig-zag time unit)
- start  in  1  one-cycle pulse; (re)starts a wave
- laserActive  in  1  laser in flight
- xLaser  in  10  laser tip x
- yLaser  in  10  laser tip y
- killingAlien  out  1  one-cycle hit pulse to laser
- xAlien  out  10  fleet origin x
- yAlien  out  10  fleet origin y
- alive  out  36  bit r*COLS+c = alien (row r, col c) alive
- canLeft  out  1  fleet may step left
- canRight  out  1  fleet may step right
- win  out  1  all aliens destroyed
- lose  out  1  fleet reached Y_LIMIT

Behaviour:
- Reset (reset=0, async): state=IDLE, alive=0, xAlien=X_START, yAlien=Y_START, dir=RIGHT, killingAlien=0, win=0, lose=0, hitLock=0.
- States: IDLE, MOVE, DESCEND, OVER.
- start in IDLE or OVER: next clock reload alive=all ones, x/y=START, dir=RIGHT, win=lose=0, hitLock=0, go to MOVE. start is ignored in MOVE/DESCEND.
- Edges are combinational from alive:
  - leftCol/rightCol = min/max column containing any alive bit.
  - botRow = max row containing any alive bit.
- canLeft = (xAlien + leftCol*SPACING_X >= STEP_X).
- canRight = (xAlien + rightCol*SPACING_X + ALIEN_W + STEP_X <= SCREEN_W).
- Both are 0 when alive==0. Compute in 11 bits, no wrap.
- MOVE, on enable:
  - dir=RIGHT and canRight: x += STEP_X.
  - dir=LEFT and canLeft: x -= STEP_X.
  - Otherwise go to DESCEND with no x change.
- DESCEND, on enable: y += STEP_Y, dir toggles, return to MOVE. Exactly one tick is spent in DESCEND.
- Without enable, state and position hold.
- Hit detection runs only in MOVE/DESCEND, combinationally:
  - dx = xLaser - xAlien, dy = yLaser - yAlien (11-bit signed; negative means no hit).
  - c = dx/SPACING_X, r = dy/SPACING_Y (shifts).
  - Hit requires c<COLS, r<ROWS, dx mod SPACING_X < ALIEN_W, dy mod SPACING_Y < ALIEN_H, alive[r*COLS+c]=1, laserActive=1 and hitLock=0.
- On a hit, the next clock clears alive bit, pulses killingAlien for exactly one cycle and sets hitLock.
- hitLock clears when laserActive=0, giving at most one kill per laser shot.
- Hit detection uses the pre-move position when a hit and enable coincide; both take effect in the same clock.
- Win: the clock after alive becomes 0, go to OVER with win=1. Win overrides a coincident move; when the last kill and enable coincide, x/y hold.
- Lose: in MOVE/DESCEND with any alien alive, if yAlien + botRow*SPACING_Y + ALIEN_H >= Y_LIMIT, go to OVER with lose=1.
- Win and lose never both assert; win has priority when both apply in the same clock.
- OVER: position and alive frozen, no hits, win/lose held until start or reset.
- Reset mid-wave aborts immediately to the reset values.

Test Plan:
- Reset then start -> next clock: alive=36'hFFFFFFFFF, xAlien=64, yAlien=32, canRight=1, canLeft=1, win=lose=0.
- Start, then 28 enable ticks -> xAlien=288 with canRight=0. Tick 29 -> DESCEND, x stays 288. Tick 30 -> yAlien=48, dir LEFT. Tick 31 -> xAlien=280.
- Fleet at (64,32), laserActive=1, xLaser=202, yLaser=69 -> one clock: alive[8] cleared, killingAlien high one cycle. Laser held -> no further kill. Drop laserActive, same coordinates -> no kill (bit dead).
- Laser at xLaser=64+32+4 (gap between columns 0 and 1) -> no kill, alive unchanged.
- Kill every column-5 alien -> canRight recomputed with rightCol=4, so the march extends 8 more ticks before descending.
- Let the fleet descend until yAlien+176>=400 (yAlien=224) -> OVER, lose=1, enable no longer moves. A start pulse restores the start values.
- Clear the last alive bit with enable in the same cycle -> win=1, x/y unchanged, lose=0.
